// File: rtl/microstep_executor.sv
// microstep_executor: registers a datapath control word from the sequencer's microstep
// code and gates the sequencer run-enable around memory steps. Optional: SINGLE_STEP_EN.
module microstep_executor #(
    parameter int unsigned SM_SIG_LEN  = 6,
    parameter int unsigned CTRL_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SM_SIG_LEN-1:0] smInput,
    input  logic                  go,
    input  logic                  mem_ready,
    input  logic                  alu_z,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [CTRL_W-1:0]     ctrl,
    output logic                  z_out,
    output logic                  halted,
    output logic                  err
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CODE_WR  = 11;
    localparam int unsigned CODE_END = 57;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_done_q, mem_done_d;
    logic               mem_req_d, mem_we_d, err_d, z_d;
    logic [CTRL_W-1:0]  ctrl_d;
    logic [7:0]         tbl;
    logic               is_mem, is_alu, step_ok;
    int unsigned        code;

`ifdef SINGLE_STEP_EN
    // One grant per rising edge of step, consumed by the next advancing cycle
    logic step_q, grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            step_q  <= step;
            grant_q <= (grant_q && !start) || (step && !step_q);
        end
    end

    assign step_ok = grant_q;
`else
    assign step_ok = 1'b1;
`endif

    // Microstep decode: memory class, ALU class and the control-word table
    always_comb begin
        code   = 32'(smInput);
        is_mem = code inside {2, 6, 10, 11};
        is_alu = code inside {[41:51]};
        tbl    = '0;
        tbl[0] = code inside {1, 4, 8};
        tbl[1] = code inside {2, 6, 10};
        tbl[2] = (code == 3);
        tbl[3] = code inside {3, 5, 9};
        tbl[4] = code inside {7, 13, 15, 17};
        tbl[5] = (code == CODE_WR);
        tbl[6] = is_alu;
        tbl[7] = is_alu;
    end

    // Next-state and run-enable
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        cnt_d      = cnt_q;
        err_d      = err;
        mem_done_d = mem_done_q;

        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_RUN;
            end
            S_RUN: begin
                if (is_mem && !mem_done_q) begin
                    state_d   = S_MEM_WAIT;
                    mem_req_d = 1'b1;
                    mem_we_d  = (code == CODE_WR);
                    cnt_d     = '0;
                end else if (step_ok) begin
                    start = 1'b1;
                    if (code == CODE_END) state_d = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ready) begin
                    mem_done_d = 1'b1;
                    state_d    = S_RUN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (go) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) start = 1'b0;
        // An advancing step retires any completed memory access
        if (start) mem_done_d = 1'b0;

        ctrl_d = start ? CTRL_W'(tbl) : '0;
        z_d    = (start && is_alu) ? alu_z : z_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mem_done_q <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            ctrl       <= '0;
            z_out      <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_done_q <= mem_done_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            ctrl       <= ctrl_d;
            z_out      <= z_d;
            halted     <= (state_d == S_HALT);
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_microstep_executor.sv
// Scoreboard bench for microstep_executor: driver feeds a reference model that queues
// expected per-cycle outputs; an independent monitor compares what the DUT presents.
module tb_microstep_executor;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] smInput;
    logic       go, mem_ready, alu_z;
    logic       start, mem_req, mem_we, z_out, halted, err;
    logic [7:0] ctrl;

    always #5 clk = ~clk;

    microstep_executor dut (
        .clk       (clk),
        .reset     (reset),
        .smInput   (smInput),
        .go        (go),
        .mem_ready (mem_ready),
        .alu_z     (alu_z),
        .start     (start),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ctrl      (ctrl),
        .z_out     (z_out),
        .halted    (halted),
        .err       (err)
    );

    typedef struct packed {
        logic       start;
        logic [7:0] ctrl;
        logic       mem_req;
        logic       mem_we;
        logic       z_out;
        logic       halted;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    bit   mem_q[$];
    int   tests = 0;
    int   failures = 0;

    // Reference model: modes, memory completion, cycles waited, visible outputs
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
    int         m_mode = M_IDLE;
    bit         m_done = 0;
    int         m_waited = 0;
    logic [7:0] m_ctrl = 8'h00;
    bit         m_z = 0, m_err = 0, m_req = 0, m_we = 0;
    bit         last_start = 0;

    function automatic logic [7:0] ctrl_of(input int c);
        logic [7:0] v;
        v = 8'h00;
        if (c == 1 || c == 4 || c == 8)               v = v | 8'h01;
        if (c == 2 || c == 6 || c == 10)              v = v | 8'h02;
        if (c == 3)                                   v = v | 8'h04;
        if (c == 3 || c == 5 || c == 9)               v = v | 8'h08;
        if (c == 7 || c == 13 || c == 15 || c == 17)  v = v | 8'h10;
        if (c == 11)                                  v = v | 8'h20;
        if (c >= 41 && c <= 51)                       v = v | 8'hC0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Apply one cycle of inputs and queue what the DUT must show for it
    task automatic drive(input bit rst, input bit g, input int code, input bit rdy, input bit z);
        exp_t e;
        bit   st;
        int   nxt;
        @(negedge clk);
        reset = rst; go = g; smInput = 6'(code); mem_ready = rdy; alu_z = z;
        st = 0; m_req = 0; m_we = 0;
        if (rst) begin
            m_mode = M_IDLE; m_done = 0; m_waited = 0;
            m_ctrl = 8'h00; m_z = 0; m_err = 0;
        end else begin
            nxt = m_mode;
            case (m_mode)
                M_IDLE: if (g) nxt = M_RUN;
                M_RUN: begin
                    if ((code == 2 || code == 6 || code == 10 || code == 11) && !m_done) begin
                        nxt = M_WAIT; m_waited = 0; m_req = 1; m_we = (code == 11);
                        mem_q.push_back(code == 11);
                    end else begin
                        st = 1;
                        if (code == 57) nxt = M_HALT;
                    end
                end
                M_WAIT: begin
                    m_waited++;
                    if (rdy) begin
                        m_done = 1; nxt = M_RUN;
                    end else if (m_waited >= 15) begin
                        m_err = 1; nxt = M_HALT;
                    end
                end
                default: if (g) nxt = M_RUN;
            endcase
            if (st) begin
                m_done = 0;
                m_ctrl = ctrl_of(code);
                if (code >= 41 && code <= 51) m_z = z;
            end else begin
                m_ctrl = 8'h00;
            end
            m_mode = nxt;
        end
        e.start = st; e.ctrl = m_ctrl; e.mem_req = m_req; e.mem_we = m_we;
        e.z_out = m_z; e.halted = (m_mode == M_HALT); e.err = m_err;
        exp_q.push_back(e);
        last_start = st;
    endtask

    // Monitor: start sampled before the edge, registered outputs after it
    initial begin : monitor
        exp_t e;
        logic st_s;
        bit   w;
        forever begin
            @(negedge clk);
            #2 st_s = start;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("start", 32'(st_s), 32'(e.start));
                chk("ctrl", 32'(ctrl), 32'(e.ctrl));
                chk("mem_req", 32'(mem_req), 32'(e.mem_req));
                chk("mem_we", 32'(mem_we), 32'(e.mem_we));
                chk("z_out", 32'(z_out), 32'(e.z_out));
                chk("halted", 32'(halted), 32'(e.halted));
                chk("err", 32'(err), 32'(e.err));
                if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        tests++; failures++;
                        $display("FAIL mem_req_unexpected: got 1 expected no request at %0t", $time);
                    end else begin
                        w = mem_q.pop_front();
                        chk("mem_we_with_req", 32'(mem_we), 32'(w));
                    end
                end
            end
        end
    end

    function automatic int pick_code();
        int r;
        r = int'($urandom_range(99));
        if (r < 45) begin
            int list[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 15, 17, 0, 12};
            return list[$urandom_range(15)];
        end
        if (r < 65) return int'($urandom_range(51, 41));
        if (r < 68) return 57;
        if (r < 73) return 56;
        return int'($urandom_range(63));
    endfunction

    initial begin : driver
        int  cur;
        bit  rdy;
        reset = 1'b1; go = 1'b0; smInput = 6'd0; mem_ready = 1'b0; alu_z = 1'b0;

        // Directed walk through reset, basic steps, memory stall, timeout, ALU and halt
        repeat (2) drive(1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 3, 0, 0);
        drive(0, 0, 2, 0, 0);
        repeat (2) drive(0, 0, 2, 0, 0);
        drive(0, 0, 2, 1, 0);
        drive(0, 0, 2, 0, 0);
        repeat (18) drive(0, 0, 11, 0, 0);
        drive(0, 1, 45, 0, 1);
        drive(0, 0, 45, 0, 1);
        drive(0, 0, 56, 0, 0);
        drive(0, 0, 57, 0, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 2, 0, 0);
        repeat (3) drive(0, 0, 2, 0, 0);
        drive(1, 0, 2, 0, 0);
        drive(0, 0, 2, 0, 0);

        // Randomised traffic; every fourth block withholds mem_ready to force timeouts
        cur = 1;
        for (int i = 0; i < 4000; i++) begin
            if (last_start || $urandom_range(7) == 0) cur = pick_code();
            rdy = ((i / 250) % 4 == 3) ? 1'b0 : ($urandom_range(4) == 0);
            drive(($urandom_range(299) == 0), ($urandom_range(3) == 0), cur, rdy,
                  1'($urandom_range(1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("mem_requests_seen", 32'(mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
